// File: rtl/chacha20_asic_top.sv
`default_nettype none
// ============================================================================
// Module : chacha20_asic_top
// ChaCha20 block: per-field key/nonce/counter acquisition, iterative rounds,
// output = input XOR keystream.
// Rev    : 1.0
// ============================================================================
module chacha20_asic_top #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  output logic         busy_o,
  output logic         done_o,
  input  logic [511:0] in_state_i,
  output logic [511:0] out_state_o,
  input  logic         use_streamed_key_i,
  input  logic         use_streamed_nonce_i,
  input  logic         use_streamed_counter_i,
  input  logic [1:0]   chunk_type_i,
  input  logic         chunk_valid_i,
  input  logic [31:0]  chunk_i,
  output logic [4:0]   chunk_index_o,
  output logic         chunk_request_o,
  output logic [1:0]   request_type_o,
  input  logic [31:0]  trng_random_number_i,
  input  logic         trng_ready_i,
  output logic         trng_request_o
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ACQ_KEY    = 3'd1;
  localparam logic [2:0] S_ACQ_NONCE  = 3'd2;
  localparam logic [2:0] S_ACQ_CTR    = 3'd3;
  localparam logic [2:0] S_CORE_START = 3'd4;
  localparam logic [2:0] S_CORE_RUN   = 3'd5;
  localparam logic [2:0] S_CORE_FINAL = 3'd6;
  localparam logic [2:0] S_DONE       = 3'd7;

  localparam int            RW         = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  logic [2:0]    state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [RW-1:0] round_q;
  logic [31:0]   fld_q [12];   // key 0..7, nonce 8..10, counter 11
  logic [31:0]   work_q [16];
  logic [511:0]  in_q;
  logic [511:0]  out_q;
  logic          use_key_q, use_nonce_q, use_ctr_q;

  logic          acq;
  logic          streamed;
  logic [1:0]    field;
  logic [4:0]    last_idx;
  logic [3:0]    base;
  logic [2:0]    next_field;
  logic          accept;
  logic [31:0]   word;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                      input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  always_comb begin
    acq        = 1'b0;
    streamed   = 1'b0;
    field      = 2'b00;
    last_idx   = 5'd0;
    base       = 4'd0;
    next_field = S_IDLE;
    case (state_q)
      S_ACQ_KEY: begin
        acq = 1'b1; streamed = use_key_q; field = 2'b00;
        last_idx = 5'd7; base = 4'd0; next_field = S_ACQ_NONCE;
      end
      S_ACQ_NONCE: begin
        acq = 1'b1; streamed = use_nonce_q; field = 2'b01;
        last_idx = 5'd2; base = 4'd8; next_field = S_ACQ_CTR;
      end
      S_ACQ_CTR: begin
        acq = 1'b1; streamed = use_ctr_q; field = 2'b10;
        last_idx = 5'd0; base = 4'd11; next_field = S_CORE_START;
      end
      default: ;
    endcase
  end

  assign accept = acq & (streamed ? (chunk_valid_i && (chunk_type_i == field)) : trng_ready_i);
  assign word   = streamed ? chunk_i : trng_random_number_i;

  assign chunk_request_o = acq & streamed;
  assign trng_request_o  = acq & ~streamed;
  assign request_type_o  = field;
  assign chunk_index_o   = idx_q;
  assign busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o          = (state_q == S_DONE);
  assign out_state_o     = out_q;

  logic [31:0] init_w [16];
  always_comb begin
    init_w[0] = 32'h61707865;
    init_w[1] = 32'h3320646e;
    init_w[2] = 32'h79622d32;
    init_w[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) init_w[4 + i] = fld_q[i];
    init_w[12] = fld_q[11];
    for (int i = 0; i < 3; i++) init_w[13 + i] = fld_q[8 + i];
  end

  // Column rounds use quarter q on (q,4+q,8+q,12+q); diagonals rotate the b/c/d rows.
  logic        diag;
  logic [31:0] qa [4];
  logic [31:0] qb [4];
  logic [31:0] qc [4];
  logic [31:0] qd [4];
  logic [31:0] rnd_w [16];
  assign diag = round_q[0];

  for (genvar q = 0; q < 4; q++) begin : g_qr
    logic [127:0] res;
    assign res = qr(work_q[q],
                    diag ? work_q[4 + ((q + 1) % 4)]  : work_q[4 + q],
                    diag ? work_q[8 + ((q + 2) % 4)]  : work_q[8 + q],
                    diag ? work_q[12 + ((q + 3) % 4)] : work_q[12 + q]);
    assign qa[q] = res[31:0];
    assign qb[q] = res[63:32];
    assign qc[q] = res[95:64];
    assign qd[q] = res[127:96];
    assign rnd_w[q]      = qa[q];
    assign rnd_w[4 + q]  = diag ? qb[(q + 3) % 4] : qb[q];
    assign rnd_w[8 + q]  = diag ? qc[(q + 2) % 4] : qc[q];
    assign rnd_w[12 + q] = diag ? qd[(q + 1) % 4] : qd[q];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_ACQ_KEY;
          idx_d   = 5'd0;
        end
      end
      S_ACQ_KEY, S_ACQ_NONCE, S_ACQ_CTR: begin
        if (accept) begin
          if (idx_q == last_idx) begin
            idx_d   = 5'd0;
            state_d = next_field;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      S_CORE_START: state_d = S_CORE_RUN;
      S_CORE_RUN:   if (round_q == LAST_ROUND) state_d = S_CORE_FINAL;
      S_CORE_FINAL: state_d = S_DONE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 5'd0;
      round_q     <= '0;
      in_q        <= '0;
      out_q       <= '0;
      use_key_q   <= 1'b0;
      use_nonce_q <= 1'b0;
      use_ctr_q   <= 1'b0;
      for (int i = 0; i < 12; i++) fld_q[i] <= '0;
      for (int i = 0; i < 16; i++) work_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            in_q        <= in_state_i;
            use_key_q   <= use_streamed_key_i;
            use_nonce_q <= use_streamed_nonce_i;
            use_ctr_q   <= use_streamed_counter_i;
          end
        end
        S_ACQ_KEY, S_ACQ_NONCE, S_ACQ_CTR: begin
          if (accept) fld_q[base + idx_q[3:0]] <= word;
        end
        S_CORE_START: begin
          for (int i = 0; i < 16; i++) work_q[i] <= init_w[i];
          round_q <= '0;
        end
        S_CORE_RUN: begin
          for (int i = 0; i < 16; i++) work_q[i] <= rnd_w[i];
          round_q <= round_q + 1'b1;
        end
        S_CORE_FINAL: begin
          for (int i = 0; i < 16; i++)
            out_q[32*i +: 32] <= in_q[32*i +: 32] ^ (work_q[i] + init_w[i]);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chacha20_asic_top.sv
`default_nettype none
// ============================================================================
// Module : tb_chacha20_asic_top
// Directed bench for chacha20_asic_top using the RFC 8439 block-function vector.
// Rev    : 1.0
// ============================================================================
module tb_chacha20_asic_top;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic [511:0] in_state;
  logic [511:0] out_state;
  logic         use_key, use_nonce, use_ctr;
  logic [1:0]   chunk_type;
  logic         chunk_valid;
  logic [31:0]  chunk;
  logic [4:0]   chunk_index;
  logic         chunk_request;
  logic [1:0]   request_type;
  logic [31:0]  trng_rn;
  logic         trng_ready;
  logic         trng_request;

  chacha20_asic_top #(.ROUNDS(20)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .start_i                (start),
    .busy_o                 (busy),
    .done_o                 (done),
    .in_state_i             (in_state),
    .out_state_o            (out_state),
    .use_streamed_key_i     (use_key),
    .use_streamed_nonce_i   (use_nonce),
    .use_streamed_counter_i (use_ctr),
    .chunk_type_i           (chunk_type),
    .chunk_valid_i          (chunk_valid),
    .chunk_i                (chunk),
    .chunk_index_o          (chunk_index),
    .chunk_request_o        (chunk_request),
    .request_type_o         (request_type),
    .trng_random_number_i   (trng_rn),
    .trng_ready_i           (trng_ready),
    .trng_request_o         (trng_request)
  );

  always #5 clk = ~clk;

  // RFC 8439 block-function keystream, word 0 in the low bits
  localparam logic [511:0] c_KS = {
    32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
    32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
    32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
    32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

  logic [31:0] rfc_key [8] = '{32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                               32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};

  int          checks   = 0;
  int          failures = 0;
  bit          alt_key  = 1'b0;
  int          n_log;
  logic [95:0] obs_log;
  int          cyc;
  bit          tmo;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tv(input logic [1:0] t, input logic [4:0] i);
    logic [2:0] k;
    k = i[2:0];
    case (t)
      2'b00:   return alt_key ? (32'h10000000 + {27'd0, i}) : rfc_key[k];
      2'b01:   return (i == 5'd0) ? 32'h09000000 : (i == 5'd1) ? 32'h4a000000 : 32'h00000000;
      default: return 32'h00000001;
    endcase
  endfunction

  // Expected acceptance order: {src, type, index} per word, src 1 = streamed
  function automatic logic [95:0] exp_log(input bit ks, input bit ns, input bit cs);
    logic [95:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = {ks, 2'b00, 5'(k)};
    for (int k = 0; k < 3; k++) v[8*(8+k) +: 8] = {ns, 2'b01, 5'(k)};
    v[88 +: 8] = {cs, 2'b10, 5'd0};
    return v;
  endfunction

  task automatic log_word(input bit src, input logic [1:0] t, input logic [4:0] i);
    if (n_log < 12) obs_log[8*n_log +: 8] = {src, t, i};
    n_log++;
  endtask

  task automatic do_start(input logic [511:0] din, input bit uk, input bit un, input bit uc);
    in_state  = din;
    use_key   = uk;
    use_nonce = un;
    use_ctr   = uc;
    start     = 1'b1;
    n_log     = 0;
    obs_log   = '0;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Serves requests until done; TRNG answers one cycle after each request.
  task automatic run_op(output int cycles, output bit timed_out);
    bit wait_trng;
    wait_trng = 1'b0;
    cycles    = 0;
    timed_out = 1'b0;
    while (done !== 1'b1 && !timed_out) begin
      chunk_valid = 1'b0;
      trng_ready  = 1'b0;
      if (chunk_request === 1'b1) begin
        chunk_type  = request_type;
        chunk       = tv(request_type, chunk_index);
        chunk_valid = 1'b1;
        log_word(1'b1, request_type, chunk_index);
      end else if (trng_request === 1'b1) begin
        if (wait_trng) begin
          trng_ready = 1'b1;
          trng_rn    = tv(request_type, chunk_index);
          wait_trng  = 1'b0;
          log_word(1'b0, request_type, chunk_index);
        end else begin
          wait_trng = 1'b1;
        end
      end
      @(negedge clk);
      cycles++;
      if (cycles > 200) timed_out = 1'b1;
    end
    chunk_valid = 1'b0;
    trng_ready  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_state = '0;
    use_key = 1'b0; use_nonce = 1'b0; use_ctr = 1'b0;
    chunk_type = 2'b00; chunk_valid = 1'b0; chunk = '0;
    trng_rn = '0; trng_ready = 1'b0;
    n_log = 0; obs_log = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_chunk_req", chunk_request, 0);
    check("rst_trng_req", trng_request, 0);
    check("rst_index", chunk_index, 0);
    check("rst_req_type", request_type, 0);
    check("rst_out", out_state, 0);

    // all fields from TRNG, RFC values
    do_start('0, 1'b0, 1'b0, 1'b0);
    run_op(cyc, tmo);
    check("t1_timeout", tmo, 0);
    check("t1_words", n_log, 12);
    check("t1_order", obs_log, exp_log(1'b0, 1'b0, 1'b0));
    check("t1_cycles", cyc, 46);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    check("t1_out", out_state, c_KS);

    // all streamed, plaintext all ones
    do_start('1, 1'b1, 1'b1, 1'b1);
    run_op(cyc, tmo);
    check("t3_timeout", tmo, 0);
    check("t3_order", obs_log, exp_log(1'b1, 1'b1, 1'b1));
    check("t3_cycles", cyc, 34);
    check("t3_out", out_state, ~c_KS);

    // streamed key with alternate values, TRNG nonce/counter
    alt_key = 1'b1;
    do_start('0, 1'b1, 1'b0, 1'b0);
    run_op(cyc, tmo);
    alt_key = 1'b0;
    check("t2_timeout", tmo, 0);
    check("t2_words", n_log, 12);
    check("t2_order", obs_log, exp_log(1'b1, 1'b0, 1'b0));
    check("t2_cycles", cyc, 38);
    check("t2_done", done, 1);

    // wrong chunk types during key phase are ignored
    do_start('0, 1'b1, 1'b1, 1'b1);
    chunk_valid = 1'b1; chunk_type = 2'b01; chunk = 32'hdeadbeef;
    @(negedge clk);
    check("t4_idx_hold0", chunk_index, 0);
    check("t4_type_hold", request_type, 2'b00);
    check("t4_req", chunk_request, 1);
    chunk_type = 2'b00; chunk = rfc_key[0];
    @(negedge clk);
    check("t4_idx_adv", chunk_index, 1);
    chunk_type = 2'b10; chunk = 32'hdeadbeef;
    @(negedge clk);
    check("t4_idx_hold1", chunk_index, 1);
    chunk_valid = 1'b0; chunk_type = 2'b00; chunk = rfc_key[1];
    @(negedge clk);
    check("t4_idx_novalid", chunk_index, 1);
    run_op(cyc, tmo);
    check("t4_timeout", tmo, 0);
    check("t4_out", out_state, c_KS);

    // start while busy is ignored (in_state not relatched)
    do_start('1, 1'b1, 1'b1, 1'b1);
    run_op(cyc, tmo);
    check("t5_pre_out", out_state, ~c_KS);
    do_start('0, 1'b1, 1'b1, 1'b1);
    in_state = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_busy", busy, 1);
    check("t5_idx", chunk_index, 0);
    run_op(cyc, tmo);
    check("t5_timeout", tmo, 0);
    check("t5_out", out_state, c_KS);

    // reset while acquiring the nonce
    do_start('1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (request_type === 2'b01) break;
      chunk_valid = chunk_request;
      chunk_type  = request_type;
      chunk       = tv(request_type, chunk_index);
      @(negedge clk);
    end
    chunk_valid = 1'b0;
    check("t5_in_nonce", request_type, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5r_busy", busy, 0);
    check("t5r_done", done, 0);
    check("t5r_chunk_req", chunk_request, 0);
    check("t5r_trng_req", trng_request, 0);
    check("t5r_index", chunk_index, 0);
    check("t5r_req_type", request_type, 0);
    check("t5r_out", out_state, 0);
    @(negedge clk);
    check("t5r_idle", busy, 0);

    // back-to-back: done held until next start, counter unchanged
    do_start('0, 1'b1, 1'b1, 1'b1);
    run_op(cyc, tmo);
    check("t6_timeout_a", tmo, 0);
    repeat (3) @(negedge clk);
    check("t6_done_held", done, 1);
    check("t6_out_held", out_state, c_KS);
    do_start('1, 1'b1, 1'b1, 1'b1);
    check("t6_done_clr", done, 0);
    check("t6_busy_set", busy, 1);
    run_op(cyc, tmo);
    check("t6_timeout_b", tmo, 0);
    check("t6_cycles", cyc, 34);
    check("t6_out", out_state, ~c_KS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
